// File: rtl/decode_sequencer.sv
// Instruction-word sequencer between fetch and decode.
// Assembles 16-bit fetch words into short (one-word) or long (two-word)
// instructions and presents each one to the decoder until it is accepted.
//
// state  | meaning
// -------+----------------------------------------------------
// FIRST  | idle, waiting for the first word of an instruction
// SECOND | first word of a long instruction held, waiting for the second
// HOLD   | assembled instruction presented on decode_valid
module decode_sequencer #(
  parameter int LONG_ENABLE = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   speedy_clock,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [15:0]            fetchoutput,
  output logic                   fetch_ready,
  input  logic                   flush,
  input  logic                   decode_ready,
  output logic                   decode_valid,
  output logic [31:0]            instr,
  output logic [11:0]            opcode,
  output logic                   is_long,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [1:0] ST_FIRST  = 2'd0;
  localparam logic [1:0] ST_SECOND = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic LONG_EN = (LONG_ENABLE != 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [15:0] first_word;
  logic        word_xfer;
  logic        issue;
  logic        starts_long;

  // Handshake qualifiers; a held instruction frees its slot in the same
  // cycle it issues, so HOLD can take a new word when the decoder accepts.
  always_comb begin
    fetch_ready  = !reset && !flush && ((state != ST_HOLD) || decode_ready);
    decode_valid = (state == ST_HOLD);
    word_xfer    = fetch_valid && fetch_ready;
    issue        = decode_valid && decode_ready && !flush;
    starts_long  = fetchoutput[15] && LONG_EN;
  end

  // State, assembly registers, presented fields and issue counter.
  always_ff @(posedge speedy_clock) begin
    if (reset) begin
      state       <= ST_FIRST;
      first_word  <= '0;
      instr       <= '0;
      opcode      <= '0;
      is_long     <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else if (flush) begin
      state      <= ST_FIRST;
      first_word <= '0;
      instr      <= '0;
      opcode     <= '0;
      is_long    <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (issue) begin
        instr_count <= instr_count + COUNT_ONE;
      end
      case (state)
        ST_FIRST, ST_HOLD: begin
          if (word_xfer) begin
            if (starts_long) begin
              first_word <= fetchoutput;
              instr      <= '0;
              opcode     <= '0;
              is_long    <= 1'b0;
              illegal    <= 1'b0;
              state      <= ST_SECOND;
            end else begin
              // Bit 15 set here only when long words are disabled: malformed.
              instr   <= {16'h0000, fetchoutput};
              opcode  <= {6'b000000, fetchoutput[14:9]};
              is_long <= 1'b0;
              illegal <= fetchoutput[15];
              state   <= ST_HOLD;
            end
          end else if (issue) begin
            instr   <= '0;
            opcode  <= '0;
            is_long <= 1'b0;
            illegal <= 1'b0;
            state   <= ST_FIRST;
          end
        end
        ST_SECOND: begin
          if (word_xfer) begin
            instr   <= {fetchoutput, first_word};
            opcode  <= {fetchoutput[14:9], first_word[14:9]};
            is_long <= 1'b1;
            illegal <= fetchoutput[15];
            state   <= ST_HOLD;
          end
        end
        default: begin
          instr   <= '0;
          opcode  <= '0;
          is_long <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: three instances (default, short-only,
// 4-bit counter) share one stimulus stream and are each checked against
// an instruction-level model every cycle, plus fixed directed expectations.
module tb_decode_sequencer;

  logic        speedy_clock = 1'b0;
  logic        reset        = 1'b1;
  logic        fetch_valid  = 1'b0;
  logic [15:0] fetchoutput  = 16'h0000;
  logic        flush        = 1'b0;
  logic        decode_ready = 1'b0;

  logic        fr_o [3];
  logic        dv_o [3];
  logic [31:0] in_o [3];
  logic [11:0] op_o [3];
  logic        lg_o [3];
  logic        il_o [3];
  logic [15:0] c0, c1;
  logic [3:0]  c2;
  logic [15:0] cnt_o [3];

  assign cnt_o[0] = c0;
  assign cnt_o[1] = c1;
  assign cnt_o[2] = {12'h000, c2};

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;

  // model state per instance
  bit          m_hi [3];
  bit          m_hf [3];
  logic [15:0] m_fw [3];
  logic [31:0] m_in [3];
  bit          m_lg [3];
  bit          m_il [3];
  int          m_cnt [3];
  int          p_le [3] = '{1, 0, 1};
  int          p_cw [3] = '{16, 16, 4};

  always #5 speedy_clock = ~speedy_clock;

  decode_sequencer #(.LONG_ENABLE(1), .COUNT_WIDTH(16)) dut0 (
    .speedy_clock(speedy_clock), .reset(reset), .fetch_valid(fetch_valid),
    .fetchoutput(fetchoutput), .fetch_ready(fr_o[0]), .flush(flush),
    .decode_ready(decode_ready), .decode_valid(dv_o[0]), .instr(in_o[0]),
    .opcode(op_o[0]), .is_long(lg_o[0]), .illegal(il_o[0]), .instr_count(c0));

  decode_sequencer #(.LONG_ENABLE(0), .COUNT_WIDTH(16)) dut1 (
    .speedy_clock(speedy_clock), .reset(reset), .fetch_valid(fetch_valid),
    .fetchoutput(fetchoutput), .fetch_ready(fr_o[1]), .flush(flush),
    .decode_ready(decode_ready), .decode_valid(dv_o[1]), .instr(in_o[1]),
    .opcode(op_o[1]), .is_long(lg_o[1]), .illegal(il_o[1]), .instr_count(c1));

  decode_sequencer #(.LONG_ENABLE(1), .COUNT_WIDTH(4)) dut2 (
    .speedy_clock(speedy_clock), .reset(reset), .fetch_valid(fetch_valid),
    .fetchoutput(fetchoutput), .fetch_ready(fr_o[2]), .flush(flush),
    .decode_ready(decode_ready), .decode_valid(dv_o[2]), .instr(in_o[2]),
    .opcode(op_o[2]), .is_long(lg_o[2]), .illegal(il_o[2]), .instr_count(c2));

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", name, idx, got, exp, $time);
  endtask

  // Instruction-level model: a pending first word, a presented instruction
  // and an issue count, advanced by the handshake rules each rising edge.
  always @(posedge speedy_clock) begin
    for (int i = 0; i < 3; i++) begin : mdl
      bit hi, hf, lg, il, rdy;
      logic [15:0] fw;
      logic [31:0] ins;
      int cnt;
      hi = m_hi[i]; hf = m_hf[i]; fw = m_fw[i]; ins = m_in[i];
      lg = m_lg[i]; il = m_il[i]; cnt = m_cnt[i];
      rdy = !reset && !flush && (!hi || decode_ready);
      if (reset) begin
        hi = 0; hf = 0; fw = 0; ins = 0; lg = 0; il = 0; cnt = 0;
      end else if (flush) begin
        hi = 0; hf = 0; fw = 0; ins = 0; lg = 0; il = 0;
      end else begin
        if (hi && decode_ready) begin
          cnt = (cnt + 1) % (1 << p_cw[i]);
          hi = 0; ins = 0; lg = 0; il = 0;
        end
        if (fetch_valid && rdy) begin
          if (hf) begin
            ins = {fetchoutput, fw}; lg = 1; il = fetchoutput[15]; hi = 1; hf = 0;
          end else if (fetchoutput[15] && p_le[i] != 0) begin
            fw = fetchoutput; hf = 1;
          end else begin
            ins = {16'h0000, fetchoutput}; lg = 0; il = fetchoutput[15]; hi = 1;
          end
        end
      end
      m_hi[i] <= hi; m_hf[i] <= hf; m_fw[i] <= fw; m_in[i] <= ins;
      m_lg[i] <= lg; m_il[i] <= il; m_cnt[i] <= cnt;
    end
  end

  // Compare DUT outputs against the model mid-cycle, after inputs settle.
  always @(negedge speedy_clock) begin
    #2;
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk("fetch_ready", i, 32'(fr_o[i]),
            32'(!reset && !flush && (!m_hi[i] || decode_ready)));
        chk("decode_valid", i, 32'(dv_o[i]), 32'(m_hi[i]));
        chk("instr_count", i, 32'(cnt_o[i]), 32'(m_cnt[i]));
        if (m_hi[i]) begin
          chk("instr", i, in_o[i], m_in[i]);
          chk("opcode", i, 32'(op_o[i]), 32'({m_in[i][30:25], m_in[i][14:9]}));
          chk("is_long", i, 32'(lg_o[i]), 32'(m_lg[i]));
          chk("illegal", i, 32'(il_o[i]), 32'(m_il[i]));
        end else if (!m_hf[i]) begin
          chk("idle_instr", i, in_o[i], 32'h0);
          chk("idle_opcode", i, 32'(op_o[i]), 32'h0);
          chk("idle_flags", i, 32'({lg_o[i], il_o[i]}), 32'h0);
        end
      end
    end
  end

  // Inputs for the coming rising edge; returns once the compare has run.
  task automatic drive(input bit fv, input logic [15:0] w, input bit dr,
                       input bit fl, input bit rs);
    @(negedge speedy_clock);
    fetch_valid = fv; fetchoutput = w; decode_ready = dr; flush = fl; reset = rs;
    #3;
  endtask

  initial begin
    drive(0, 16'h0, 0, 0, 1);
    armed = 1'b1;
    drive(0, 16'h0, 0, 0, 1);
    chk("rst_valid", 0, 32'(dv_o[0]), 32'h0);
    chk("rst_count", 0, 32'(cnt_o[0]), 32'h0);
    chk("rst_fetch_ready", 0, 32'(fr_o[0]), 32'h0);

    // short word, one-cycle latency
    drive(1, 16'h1234, 1, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    chk("short_valid", 0, 32'(dv_o[0]), 32'h1);
    chk("short_instr", 0, in_o[0], 32'h00001234);
    chk("short_opcode", 0, 32'(op_o[0]), 32'h009);
    chk("short_is_long", 0, 32'(lg_o[0]), 32'h0);
    drive(1, 16'h8A00, 1, 0, 0);
    chk("short_count", 0, 32'(cnt_o[0]), 32'h1);

    // long instruction
    drive(1, 16'h0600, 1, 0, 0);
    drive(1, 16'h0011, 1, 0, 0);
    chk("long_instr", 0, in_o[0], 32'h06008A00);
    chk("long_opcode", 0, 32'(op_o[0]), 32'h0C5);
    chk("long_is_long", 0, 32'(lg_o[0]), 32'h1);
    chk("long_illegal", 0, 32'(il_o[0]), 32'h0);

    // back-to-back short issue, then decoder stall
    for (int k = 1; k <= 4; k++) drive(1, 16'(16'h0011 + k), 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0016, 0, 0, 0);
      chk("stall_count", 0, 32'(cnt_o[0]), 32'd6);
      chk("stall_instr", 0, in_o[0], 32'h00000015);
      chk("stall_fetch_ready", 0, 32'(fr_o[0]), 32'h0);
    end
    drive(0, 16'h0, 1, 0, 0);

    // flush while holding a first word
    drive(1, 16'h8123, 1, 0, 0);
    drive(1, 16'h0456, 1, 1, 0);
    chk("flush_fetch_ready", 0, 32'(fr_o[0]), 32'h0);
    drive(0, 16'h0, 1, 0, 0);
    chk("flush_valid", 0, 32'(dv_o[0]), 32'h0);
    chk("flush_count", 0, 32'(cnt_o[0]), 32'd7);

    // malformed instructions
    drive(1, 16'h8A00, 1, 0, 0);
    drive(1, 16'h8000, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    chk("ill_long_valid", 0, 32'(dv_o[0]), 32'h1);
    chk("ill_long_illegal", 0, 32'(il_o[0]), 32'h1);
    chk("ill_long_instr", 0, in_o[0], 32'h80008A00);
    chk("ill_short_illegal", 1, 32'(il_o[1]), 32'h1);
    chk("ill_short_instr", 1, in_o[1], 32'h00008000);
    chk("ill_short_is_long", 1, 32'(lg_o[1]), 32'h0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    chk("ill_issued_count", 0, 32'(cnt_o[0]), 32'd8);
    chk("ill_issued_count", 1, 32'(cnt_o[1]), 32'd10);

    // counter wrap on the 4-bit instance
    drive(0, 16'h0, 0, 0, 1);
    for (int k = 0; k < 17; k++) drive(1, 16'h0001, 1, 0, 0);
    drive(0, 16'h0, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    chk("wrap_count", 2, 32'(cnt_o[2]), 32'd1);
    chk("wrap_count", 0, 32'(cnt_o[0]), 32'd17);

    // reset while presenting
    drive(1, 16'h1111, 1, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    chk("hold_valid", 0, 32'(dv_o[0]), 32'h1);
    drive(0, 16'h0, 0, 0, 1);
    chk("rst_hold_fetch_ready", 0, 32'(fr_o[0]), 32'h0);
    drive(0, 16'h0, 0, 0, 0);
    chk("rst_hold_valid", 0, 32'(dv_o[0]), 32'h0);
    chk("rst_hold_instr", 0, in_o[0], 32'h0);
    chk("rst_hold_opcode", 0, 32'(op_o[0]), 32'h0);
    chk("rst_hold_flags", 0, 32'({lg_o[0], il_o[0]}), 32'h0);
    chk("rst_hold_count", 0, 32'(cnt_o[0]), 32'h0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 149) == 0));
    end

    drive(0, 16'h0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The module SHALL have parameter LONG_ENABLE, default 1: 1 = 32-bit two-word instructions accepted; 0 = every word is short.
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 16: width of the issued-instruction counter.
REQ-003 The module SHALL have port speedy_clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port fetch_valid  input  1  fetchoutput holds a valid 16-bit instruction word.
REQ-006 The module SHALL have port fetchoutput  input  16  instruction word from fetch.
REQ-007 The module SHALL have port fetch_ready  output  1  sequencer accepts the word this cycle.
REQ-008 The module SHALL have port flush  input  1  discard the partial instruction and any held instruction.
REQ-009 The module SHALL have port decode_ready  input  1  downstream decoder accepts the presented instruction.
REQ-010 The module SHALL have port decode_valid  output  1  instr, opcode, is_long and illegal are valid.
REQ-011 The module SHALL have port instr  output  32  assembled instruction: {second word, first word}; upper half zero for short.
REQ-012 The module SHALL have port opcode  output  12  {second[14:9], first[14:9]}; upper 6 bits zero for short.
REQ-013 The module SHALL have port is_long  output  1  the held instruction is two words.
REQ-014 The module SHALL have port illegal  output  1  the held instruction is malformed.
REQ-015 The module SHALL have port instr_count  output  COUNT_WIDTH  number of instructions issued.

Function
REQ-016 The module SHALL have three states: FIRST (awaiting first word), SECOND (first word held, awaiting second), HOLD (instruction presented).
REQ-017 A word SHALL transfer only on fetch_valid && fetch_ready; an instruction SHALL issue only on decode_valid && decode_ready.
REQ-018 fetch_ready SHALL be a combinational function of state: 1 in FIRST and SECOND, decode_ready in HOLD, and 0 whenever flush=1.
REQ-019 decode_valid SHALL be 1 exactly in HOLD; instr, opcode, is_long and illegal SHALL remain stable while in HOLD and not issued.
REQ-020 First-word transfer with bit15=0, or with LONG_ENABLE=0, SHALL load a short instruction and go to HOLD the next cycle (1-cycle latency).
REQ-021 First-word transfer with bit15=1 and LONG_ENABLE=1 SHALL store the word and go to SECOND.
REQ-022 Second-word transfer in SECOND SHALL load the long instruction (is_long=1) and go to HOLD.
REQ-023 illegal SHALL be set when a second word has bit15=1, or when LONG_ENABLE=0 and the first word has bit15=1; the instruction still goes through HOLD and issues normally.
REQ-024 In HOLD, an issue with no simultaneous transfer SHALL go to FIRST.
REQ-025 In HOLD, an issue with a simultaneous first-word transfer SHALL apply REQ-020/021 to the new word, giving back-to-back short issue at one instruction per cycle.
REQ-026 In SECOND with fetch_valid=0, the first word SHALL be held indefinitely.
REQ-027 flush SHALL take priority over all transfers and issues except reset: next state FIRST, partial word discarded, no issue counted, instr_count unchanged.
REQ-028 instr_count SHALL increment by 1 on each issue and wrap from all-ones to 0.
REQ-029 Output fields SHALL be cleared to zero whenever the next state is FIRST.

Reset
REQ-030 reset=1 at a rising edge SHALL force state FIRST, and set decode_valid, instr, opcode, is_long, illegal and instr_count to 0.
REQ-031 reset SHALL override flush and any in-progress transfer or issue, including an instruction mid-assembly in SECOND.
REQ-032 While reset=1, fetch_ready SHALL be 0.

Verification
REQ-033 Bench: short word 0x1234 with decode_ready=1 -> next cycle decode_valid=1, instr=0x00001234, opcode=0x009, is_long=0; following cycle instr_count=1.
REQ-034 Bench: words 0x8A00 then 0x0600 -> after second, instr=0x06008A00, opcode=0x0C5, is_long=1, illegal=0.
REQ-035 Bench: continuous valid short words with decode_ready=1 -> one issue per cycle; decode_ready=0 for 3 cycles -> outputs stable, fetch_ready=0.
REQ-036 Bench: flush while in SECOND, with fetch_valid=1 -> state FIRST, fetch_ready=0 that cycle, word dropped, no issue, instr_count unchanged.
REQ-037 Bench: second word 0x8000, and separately LONG_ENABLE=0 with first word 0x8000 -> illegal=1 presented and issued.
REQ-038 Bench: instr_count preset near wrap via COUNT_WIDTH=4, issue 17 instructions -> reads 1; reset asserted mid-HOLD -> all outputs 0 next cycle.
